// File: rtl/mr_latch_sar_pkg.sv
// rtl/mr_latch_sar_pkg.sv - shared types, defaults and helpers for the latch-comparator SAR controller
package mr_latch_sar_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_CMP_INVERT    = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } sar_state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mr_latch_sync.sv
// rtl/mr_latch_sync.sv - multi-flop synchronizer for asynchronous pad/analog levels
module mr_latch_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/mr_latch_sar_ctrl.sv
// rtl/mr_latch_sar_ctrl.sv - successive-approximation controller driving the DAC and reading the latch comparator
module mr_latch_sar_ctrl
  import mr_latch_sar_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CMP_INVERT    = DEF_CMP_INVERT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int W      = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_MAX = (SAMPLE_CYCLES > W) ? SAMPLE_CYCLES : W;
  localparam int CW     = cnt_width(CNT_MAX + 1);
  localparam int IW     = cnt_width(WIDTH);

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(W - 1);
  localparam logic [IW-1:0] TOP_BIT     = IW'(WIDTH - 1);
  localparam logic          CMP_POL     = (CMP_INVERT != 0);

  sar_state_e       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_dec;
  logic             cmp_raw;
  logic             cmp_s;

  assign cmp_raw = cmp_in ^ CMP_POL;

  mr_latch_sync #(.STAGES(SYNC_STAGES)) u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_raw),
    .q   (cmp_s)
  );

  assign acc_dec = acc | (WIDTH'(cmp_s) << bit_idx);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      acc          <= '0;
      sample_en    <= 1'b0;
      dac_code     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SAMPLE;
            sample_en <= 1'b1;
            cnt       <= '0;
            acc       <= '0;
            result    <= '0;
            dac_code  <= '0;
          end
        end
        ST_SAMPLE: begin
          if (cnt == SAMPLE_LAST) begin
            state     <= ST_SETTLE;
            sample_en <= 1'b0;
            cnt       <= '0;
            bit_idx   <= TOP_BIT;
            dac_code  <= WIDTH'(1) << TOP_BIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_DECIDE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DECIDE: begin
          acc <= acc_dec;
          if (bit_idx == '0) begin
            state        <= ST_DONE;
            dac_code     <= acc_dec;
            result       <= acc_dec;
            result_valid <= 1'b1;
          end else begin
            state    <= ST_SETTLE;
            bit_idx  <= bit_idx - 1'b1;
            dac_code <= acc_dec | (WIDTH'(1) << (bit_idx - 1'b1));
          end
        end
        ST_DONE: begin
          // A start coinciding with the transfer chains straight into the next conversion.
          if (result_ready) begin
            result_valid <= 1'b0;
            if (start) begin
              state     <= ST_SAMPLE;
              sample_en <= 1'b1;
              cnt       <= '0;
              acc       <= '0;
              result    <= '0;
              dac_code  <= '0;
            end else begin
              state    <= ST_IDLE;
              dac_code <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mr_latch_sar_ctrl.sv
// tb/tb_mr_latch_sar_ctrl.sv - scoreboard bench for mr_latch_sar_ctrl
module tb_mr_latch_sar_ctrl;

  localparam int LAT  = 44;
  localparam int LAT2 = 52;

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, result_ready, cmp_in;
  logic       sample_en, busy, result_valid;
  logic [7:0] dac_code, result, v_in;

  logic       start2, ready2, cmp_in2;
  logic       sample_en2, busy2, result_valid2;
  logic [7:0] dac_code2, result2, v2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t sb_q[$];
  exp_t sb2_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cmp_in  = (dac_code <= v_in);
  assign cmp_in2 = !(dac_code2 <= v2);

  mr_latch_sar_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_in),
    .sample_en(sample_en), .dac_code(dac_code), .busy(busy),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  mr_latch_sar_ctrl #(.CMP_INVERT(1), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cmp_in(cmp_in2),
    .sample_en(sample_en2), .dac_code(dac_code2), .busy(busy2),
    .result(result2), .result_valid(result_valid2), .result_ready(ready2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  logic       prev_valid = 1'b0;
  logic       prev_xfer  = 1'b0;
  logic [7:0] prev_res   = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (result_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("latency_cycle", cyc, e.cyc);
        end
      end else if (result_valid && prev_valid && !prev_xfer) begin
        chk("result_stable", result, prev_res);
      end
    end
    prev_valid = result_valid;
    prev_res   = result;
    prev_xfer  = result_valid && result_ready;
  end

  logic prev_valid2 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid2 && !prev_valid2) begin
      if (sb2_q.size() == 0) begin
        chk("unexpected_valid2", 32'd1, 32'd0);
      end else begin
        e = sb2_q.pop_front();
        chk("result2", result2, e.res);
        chk("latency_cycle2", cyc, e.cyc);
      end
    end
    prev_valid2 = result_valid2;
  end

  task automatic issue(input logic [7:0] v, input logic [7:0] exp);
    v_in  = v;
    start = 1'b1;
    sb_q.push_back('{exp, cyc + 1 + LAT});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!result_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic convert(input logic [7:0] v, input logic [7:0] exp, input bit chk_pat);
    logic [7:0] pat [8];
    int sen = 0;
    pat = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    issue(v, exp);
    for (int t = 0; t < LAT; t++) begin
      @(negedge clk);
      if (sample_en) sen++;
      if (chk_pat && t >= 4) chk("dac_seq", dac_code, pat[(t - 4) / 5]);
    end
    chk("sample_len", sen, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_xfer", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; result_ready = 1'b1; v_in = '0;
    start2 = 1'b0; ready2 = 1'b1; v2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_sample_en", sample_en, 1'b0);
    chk("rst_dac_code", dac_code, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_result_valid", result_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    convert(8'hA5, 8'hA5, 1'b1);
    convert(8'h00, 8'h00, 1'b0);
    convert(8'hFF, 8'hFF, 1'b0);

    // Backpressure with an ignored start during the stall
    result_ready = 1'b0;
    issue(8'h3C, 8'h3C);
    wait_valid(60);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 start = (k == 3);
    end
    start = 1'b0;
    chk("bp_valid_held", result_valid, 1'b1);
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid_dropped", result_valid, 1'b0);
    chk("bp_idle", busy, 1'b0);
    repeat (5) @(negedge clk);
    chk("bp_start_not_queued", busy, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back: start coincides with the transfer
    result_ready = 1'b0;
    issue(8'h3C, 8'h3C);
    wait_valid(60);
    @(posedge clk);
    #1;
    result_ready = 1'b1;
    start = 1'b1;
    v_in = 8'hC3;
    sb_q.push_back('{8'hC3, cyc + 1 + LAT});
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_sample_en", sample_en, 1'b1);
    wait_valid(60);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset during bit 3 settle
    issue(8'h5A, 8'h5A);
    repeat (26) @(negedge clk);
    chk("pre_rst_dac", dac_code, 8'h58);
    #2 rst = 1'b1;
    #1;
    sb_q.delete();
    chk("arst_sample_en", sample_en, 1'b0);
    chk("arst_dac_code", dac_code, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_result", result, 8'h00);
    chk("arst_result_valid", result_valid, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    convert(8'h5A, 8'h5A, 1'b0);

    // Inverted comparator, three-stage synchronizer
    v2 = 8'h77;
    start2 = 1'b1;
    sb2_q.push_back('{8'h77, cyc + 1 + LAT2});
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int n = 0; n < 70 && !result_valid2; n++) @(negedge clk);
    chk("inv_valid_seen", result_valid2, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    chk("sb_drained", sb_q.size(), 32'd0);
    chk("sb2_drained", sb2_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mr_latch_sar_ctrl.md
Name: mr_latch_sar_ctrl

Overview:
- Digital successive-approximation controller that sits directly downstream of the latch comparator macro.
- It consumes the comparator decision (comparator `Out` routed in as an asynchronous digital level) and drives a trial code to the external/R-2R DAC feeding the comparator's reference input.
- It runs a binary search and delivers a WIDTH-bit conversion result over a valid/ready handshake.

Parameters:
- WIDTH, 8: result and DAC code width (2..12).
- SAMPLE_CYCLES, 4: cycles `sample_en` is held high for track/hold (>=1).
- SETTLE_CYCLES, 2: DAC/comparator settling cycles before each decision (>=0).
- SYNC_STAGES, 2: flops in the comparator synchronizer (>=2).
- CMP_INVERT, 0: 1 = comparator output is active-low (inverted before use).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE.
- cmp_in  in  1  raw comparator output, asynchronous to clk; 1 means analog input > DAC level.
- sample_en  out  1  track/hold control; high during SAMPLE.
- dac_code  out  WIDTH  trial code presented to the DAC.
- busy  out  1  high in every state except IDLE.
- result  out  WIDTH  conversion result; valid only while result_valid=1.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.

Behaviour:
- Reset: asynchronous, active-high; the clock is clk.
  - rst=1 forces state IDLE, all counters and synchronizer flops to 0, and every output to 0 (sample_en, dac_code, busy, result, result_valid).
  - Reset mid-conversion aborts immediately, with no partial result and no valid pulse.
- Synchronizer: cmp_s = cmp_in (XOR CMP_INVERT) through SYNC_STAGES flops. It is the only path from cmp_in into logic.
- Wait per bit: W = SETTLE_CYCLES + SYNC_STAGES.
- IDLE:
  - busy=0, dac_code=0.
  - start=1 at a clock edge → SAMPLE; result register cleared.
- SAMPLE:
  - sample_en=1 for exactly SAMPLE_CYCLES cycles.
  - Then bit index i=WIDTH-1 → SETTLE.
- SETTLE:
  - dac_code = acc | (1<<i), where acc holds the bits already decided.
  - Held for W cycles, then → DECIDE.
- DECIDE (1 cycle):
  - If cmp_s=1, bit i of acc is set; otherwise it stays 0.
  - If i=0 → DONE; otherwise i decrements → SETTLE.
  - dac_code is unchanged during DECIDE.
- DONE:
  - result=acc and result_valid=1; busy=1; dac_code holds the final acc.
  - result and result_valid are held stable until result_ready=1.
  - On transfer (valid & ready): if start=1 in the same cycle → SAMPLE (back-to-back), else → IDLE.
- Latency: result_valid rises exactly SAMPLE_CYCLES + WIDTH*(W+1) cycles after the edge that samples start. With defaults this is 4 + 8*5 = 44.
- start while busy (SAMPLE/SETTLE/DECIDE, or DONE without ready) is ignored and not queued.
- result_ready outside DONE is ignored.
- Arithmetic: unsigned, plain binary search. The result is the largest code c with the comparator reporting input > DAC(c) at every kept bit. No overflow is possible.
- Counters:
  - sample/settle counter width is clog2(max(SAMPLE_CYCLES, W)+1).
  - bit index width is clog2(WIDTH).
- All outputs are registered except busy, which may be decoded from state.

Decomposition:
- Package mr_latch_sar_pkg holds:
  - the state enum (IDLE, SAMPLE, SETTLE, DECIDE, DONE);
  - a cnt_width(n) constant function;
  - the default parameter constants.
- Sub-module mr_latch_sync: parameterized SYNC_STAGES flop chain with async active-high reset to 0, reusable for other async pad/analog inputs.
- FSM, counters and accumulator stay in mr_latch_sar_ctrl.

Test Plan:
- Comparator model: cmp_in = (dac_code <= V), applied combinationally.
- V=0xA5, defaults, pulse start:
  - dac_code sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, each held 5 cycles.
  - result_valid rises exactly 44 cycles after start; result=0xA5.
- V=0x00 → result 0x00. V=0xFF → result 0xFF.
  - Both complete in 44 cycles; sample_en is high exactly 4 cycles.
- Backpressure:
  - Hold result_ready=0 for 10 cycles after valid; result and result_valid stay stable.
  - Pulse start during that window → ignored. Ready=1 → one transfer, then IDLE.
- Back-to-back:
  - Assert start with result_ready in the transfer cycle (V changes 0x3C → 0xC3).
  - The second result, 0xC3, arrives 44 cycles after the transfer edge, with no idle cycle between.
- Reset mid-conversion:
  - Assert rst asynchronously (between edges) during bit 3 SETTLE.
  - All outputs are 0 immediately; after release, start converts V=0x5A correctly with no stale valid.
- CMP_INVERT=1 with the inverted comparator model, V=0x77 → result 0x77. SYNC_STAGES=3 → latency 52.
